// File: rtl/tb_obi_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_mem_arbiter_if
// Description : OBI-style request/response bundle shared by the arbiter's
//               instruction, data and memory ports.
//               master      - requester side (drives req and its fields)
//               slave       - responder side (drives gnt/rvalid/rdata)
//               instr_*     - the same without we/be/wdata, which a
//                             read-only fetch port never carries
// Revision    : 1.0 - initial release
// ============================================================================
interface tb_obi_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );

    modport instr_master (
        output req, addr,
        input  gnt, rvalid, rdata
    );

    modport instr_slave (
        input  req, addr,
        output gnt, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/tb_obi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_mem_arbiter
// Description : Shares one single-port RAM between the core's instruction
//               and data OBI ports. Round-robin selection onto the memory
//               port, a selection lock while a request waits for its grant,
//               an in-order owner-ID FIFO that routes each response back to
//               the port that issued it, and a sticky protocol-error flag.
//               Optional feature macro: TB_OBI_ARB_RANDOM_STALL_EN
//               (LFSR-driven request suppression modelling memory-side
//               contention). Undefined by default: no stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    tb_obi_mem_arbiter_if.instr_slave   instr,
    tb_obi_mem_arbiter_if.slave         data,
    tb_obi_mem_arbiter_if.master        mem,
    output logic                        err_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_BE_W  = DATA_WIDTH / 8;

    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(MAX_OUTSTANDING);

    // Owner IDs stored in the FIFO and in the round-robin history
    localparam logic c_ID_INSTR = 1'b0;
    localparam logic c_ID_DATA  = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                r_fifo [MAX_OUTSTANDING];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_last_grant;
    logic                r_lock;
    logic                r_lock_owner;
    logic                r_err;

    // ------------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------------
    logic w_sel;        // selected owner ID
    logic w_want;       // selected port is requesting
    logic w_full;
    logic w_empty;
    logic w_stall;
    logic w_mem_req;
    logic w_hs;         // request handshake on the memory port
    logic w_pop;        // response accepted from memory
    logic w_head;       // owner of the oldest outstanding transaction
    logic w_err_set;

    // Pointer advance with wrap at the last FIFO slot (depth need not be 2^n)
    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef TB_OBI_ARB_RANDOM_STALL_EN
    // ------------------------------------------------------------------------
    // Contention model: Fibonacci LFSR x^16+x^14+x^13+x^11+1
    // ------------------------------------------------------------------------
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Free-running LFSR, reseeded on reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Selection
    // ------------------------------------------------------------------------
    // A locked selection holds its owner; otherwise a lone requester wins and
    // a conflict goes to the port that was not granted last.
    always_comb begin
        w_sel  = c_ID_INSTR;
        w_want = 1'b0;
        if (r_lock) begin
            w_sel  = r_lock_owner;
            w_want = r_lock_owner ? data.req : instr.req;
        end else if (instr.req && data.req) begin
            w_sel  = ~r_last_grant;
            w_want = 1'b1;
        end else if (data.req) begin
            w_sel  = c_ID_DATA;
            w_want = 1'b1;
        end else if (instr.req) begin
            w_sel  = c_ID_INSTR;
            w_want = 1'b1;
        end
    end

    assign w_full  = (r_count == c_CNT_FULL);
    assign w_empty = (r_count == '0);

    // A pending locked request is never withdrawn by full or stall; a lock
    // only forms below full, so the full gate never actually meets it.
    assign w_mem_req = rst_ni & w_want & (r_lock | (~w_full & ~w_stall));
    assign w_hs      = w_mem_req & mem.gnt;

    // ------------------------------------------------------------------------
    // Request path (zero latency)
    // ------------------------------------------------------------------------
    assign mem.req   = w_mem_req;
    assign mem.addr  = w_sel ? data.addr : instr.addr;
    assign mem.we    = w_sel & data.we;
    assign mem.be    = w_sel ? data.be : {c_BE_W{1'b1}};
    assign mem.wdata = w_sel ? data.wdata : '0;

    assign instr.gnt = w_hs & ~w_sel;
    assign data.gnt  = w_hs &  w_sel;

    // ------------------------------------------------------------------------
    // Response path (zero latency)
    // ------------------------------------------------------------------------
    assign w_head = r_fifo[r_rd_ptr];
    assign w_pop  = rst_ni & mem.rvalid & ~w_empty;

    assign instr.rvalid = w_pop & ~w_head;
    assign data.rvalid  = w_pop &  w_head;
    assign instr.rdata  = mem.rdata;
    assign data.rdata   = mem.rdata;

    // Orphan response, or a locked requester withdrawing before its grant
    assign w_err_set = (mem.rvalid & w_empty) | (r_lock & ~w_want);

    assign err_o = r_err;

    // ------------------------------------------------------------------------
    // Sequential state: ID FIFO, round-robin history, lock, error flag
    // ------------------------------------------------------------------------
    // Single update point for all arbiter state; reset discards outstanding IDs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo[i] <= 1'b0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_last_grant <= c_ID_DATA;
            r_lock       <= 1'b0;
            r_lock_owner <= c_ID_INSTR;
            r_err        <= 1'b0;
        end else begin
            if (w_hs) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= f_ptr_inc(r_wr_ptr);
                r_last_grant     <= w_sel;
            end

            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end

            case ({w_hs, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Lock follows an ungranted request; a handshake or a dropped
            // request leaves mem_req/gnt such that this clears it.
            r_lock       <= w_mem_req & ~mem.gnt;
            r_lock_owner <= w_sel;

            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
